// File: rtl/uart_tx.sv
// 8N1 asynchronous serial transmitter, LSB first, CLKS_PER_BIT clocks per bit.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop (8E1).
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1231
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din_tx,
    output logic                  serial_tx,
    output logic                  busy,
    output logic                  done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
        return ^word;
    endfunction

    logic parity_q, parity_d;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         index_q, index_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  fin_q, fin_d;
    logic                  done_q, done_d;
    logic                  tick_s;

    // Next-state, bit timing and line value; outputs lag the state by one register stage.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        index_d  = index_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        fin_d    = 1'b0;
        tx_d     = 1'b1;
        busy_d   = (state_q != S_IDLE);
        done_d   = fin_q;
        tick_s   = (timer_q == TIMER_LAST);

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                // busy_q still reads high in the first idle cycle, so a start there is ignored
                if (start && !busy_q) begin
                    shift_d  = din_tx;
                    timer_d  = '0;
                    index_d  = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(din_tx);
`endif
                    state_d  = S_START;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (tick_s) begin
                    timer_d = '0;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (tick_s) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    index_d = index_q + IW'(1);
                    if (index_q == INDEX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_d = parity_q;
                if (tick_s) begin
                    timer_d = '0;
                    state_d = S_STOP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (tick_s) begin
                    timer_d = '0;
                    fin_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            index_q  <= '0;
            shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            index_q  <= index_d;
            shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            fin_q    <= fin_d;
            done_q   <= done_d;
        end
    end

    assign serial_tx = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a fast instance (4 clocks/bit) under random traffic
// and a default-rate instance (1231 clocks/bit) for one full-length frame.
module tb_uart_tx;

    localparam int  C  = 4;
    localparam int  C2 = 1231;
    localparam int  W  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int  NB = W + 3;
`else
    localparam int  NB = W + 2;
`endif
    localparam int  FL = NB * C;
    localparam time P  = 10;

    logic       clk;
    logic       reset;
    logic       start, start2;
    logic [7:0] din_tx, din2;
    logic       serial_tx, busy, done;
    logic       serial_tx2, busy2, done2;

    uart_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset(reset), .start(start), .din_tx(din_tx),
        .serial_tx(serial_tx), .busy(busy), .done(done)
    );

    uart_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .din_tx(din2),
        .serial_tx(serial_tx2), .busy(busy2), .done(done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] data;
        time        t_acc;
    } exp_t;

    exp_t exp_q[$];
    time  done_q[$];
    time  free_at;
    int   checks;
    int   errors;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Line image of one frame: start 0, data LSB first, optional even parity, stop 1.
    function automatic logic [15:0] frame_bits(input logic [7:0] d);
        logic [15:0] f;
        f    = 16'hFFFF;
        f[0] = 1'b0;
        for (int i = 0; i < W; i++) f[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[W + 1] = ^d;
`endif
        return f;
    endfunction

    // Called at a negedge; models acceptance at the following posedge.
    task automatic issue(input logic [7:0] d);
        exp_t e;
        start  = 1'b1;
        din_tx = d;
        @(posedge clk);
        if (reset && $time >= free_at) begin
            e.data  = d;
            e.t_acc = $time;
            exp_q.push_back(e);
            done_q.push_back($time + (FL + 1) * P);
            free_at = $time + (FL + 2) * P;
        end
        @(negedge clk);
        start  = 1'b0;
        din_tx = 8'($urandom);
    endtask

    task automatic wait_free();
        while ($time + 5 < free_at) @(negedge clk);
    endtask

    // Receiver: samples each bit in its middle and compares the frame against the model.
    initial begin
        logic        rx_active;
        int          rx_cnt;
        time         rx_t0;
        logic [15:0] rx_bits;
        exp_t        e;
        rx_active = 1'b0;
        rx_cnt    = 0;
        rx_t0     = 0;
        rx_bits   = 16'hFFFF;
        forever begin
            @(negedge clk);
            if (!reset) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (serial_tx == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                    rx_t0     = $time;
                    rx_bits   = 16'hFFFF;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % C == C / 2) begin
                    rx_bits[rx_cnt / C] = serial_tx;
                    if (rx_cnt / C == NB - 1) begin
                        rx_active = 1'b0;
                        if (exp_q.size() == 0) begin
                            check("rx_unexpected_frame", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("rx_frame_bits", rx_bits, frame_bits(e.data));
                            check("rx_data", rx_bits[W:1], e.data);
                            check("rx_start_time", rx_t0, e.t_acc + P + 5);
                        end
                    end
                end
            end
        end
    end

    // Done monitor: pulse timing, busy low in the done cycle, busy length per frame.
    initial begin
        int  busy_run;
        time t;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_run = 0;
            end else begin
                if (busy) busy_run++;
                if (done) begin
                    if (done_q.size() == 0) begin
                        check("done_unexpected", 1, 0);
                    end else begin
                        t = done_q.pop_front();
                        check("done_time", $time - 5, t);
                        check("done_busy_low", busy, 0);
                        check("busy_len", busy_run, FL);
                    end
                    busy_run = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hello [5];
        logic [7:0] b2;
        logic [15:0] f2;
        time         t2;
        int          n;
        logic        seen;
        hello   = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        checks  = 0;
        errors  = 0;
        free_at = 0;
        reset   = 1'b0;
        start   = 1'b0;
        start2  = 1'b0;
        din_tx  = 8'h00;
        din2    = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", serial_tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 1'b1;

        // Single frame, 8'h48, with clear idle before and after.
        issue(8'h48);
        wait_free();
        repeat (3) @(negedge clk);

        // HELLO, each byte issued in the previous done cycle.
        for (int i = 0; i < 5; i++) begin
            wait_free();
            issue(hello[i]);
        end

        // Start pulse with 8'hFF in the middle of an 8'h00 frame is ignored.
        wait_free();
        issue(8'h00);
        repeat (3 * C) @(negedge clk);
        issue(8'hFF);

        // Reset during data bit 3 abandons the frame.
        wait_free();
        issue(8'hA5);
        repeat (4 * C + 1) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_tx", serial_tx, 1);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        exp_q.delete();
        done_q.delete();
        free_at = 0;
        @(negedge clk);
        reset = 1'b1;
        issue(8'h3C);

        // Random traffic with random gaps and random ignored starts.
        for (int k = 0; k < 20; k++) begin
            wait_free();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(8'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, FL - 5)) @(negedge clk);
                issue(8'($urandom));
            end
        end
        wait_free();
        repeat (4) @(negedge clk);
        check("pending_frames", exp_q.size(), 0);
        check("pending_dones", done_q.size(), 0);

        // Default-rate instance: one full frame sampled at mid-bit.
        b2     = 8'($urandom);
        f2     = frame_bits(b2);
        start2 = 1'b1;
        din2   = b2;
        @(posedge clk);
        t2 = $time;
        @(negedge clk);
        start2 = 1'b0;
        din2   = 8'($urandom);
        seen   = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (serial_tx2 == 1'b0) seen = 1'b1;
            else @(negedge clk);
        end
        check("slow_start_seen", seen, 1);
        check("slow_start_time", $time, t2 + P + 5);
        for (int k = 0; k < NB; k++) begin
            repeat ((k == 0) ? C2 / 2 : C2) @(negedge clk);
            check("slow_bit", serial_tx2, f2[k]);
        end
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 2 * C2) begin
            @(negedge clk);
            n++;
            if (done2) seen = 1'b1;
        end
        check("slow_done_seen", seen, 1);
        check("slow_done_time", $time, t2 + (NB * C2 + 1) * P + 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
